// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch requester, data requester and
// the shared memory port. "slave" is the arbiter's view; "master" is the view
// of everything around it (pipeline requesters and the memory).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch requester
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            flush_if;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;
    logic            stall_if;

    // Data requester
    logic            dm_req;
    logic            dm_we;
    logic [DW/8-1:0] dm_be;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW-1:0]   dm_rdata;
    logic            dm_valid;
    logic            stall_dm;

    // Shared memory port
    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, flush_if,
        output if_rdata, if_valid, stall_if,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_valid, stall_dm,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, flush_if,
        input  if_rdata, if_valid, stall_if,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid, stall_dm,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch and
// load/store. One transaction in flight; DM has priority unless fetch has been
// passed over STARVE_LIMIT times in a row. A flushed fetch still completes on
// the bus but its response is dropped.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int         BW    = DW / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} stateT;
    typedef enum logic {OWNER_IF, OWNER_DM} ownerT;

    stateT          state;
    ownerT          owner;
    logic           discard;
    logic [3:0]     starveCnt;

    logic           memReq;
    logic           memWe;
    logic [BW-1:0]  memBe;
    logic [AW-1:0]  memAddr;
    logic [DW-1:0]  memWdata;
    logic [DW-1:0]  ifRdata;
    logic [DW-1:0]  dmRdata;
    logic           ifValidQ;
    logic           dmValidQ;

    logic           dmWins;
    logic           ifWins;
    logic           ifFlushHit;
    logic           ifValid;

    // DM wins a capture unless fetch is waiting and has hit the starvation limit;
    // a fetch being flushed this cycle is never captured.
    assign dmWins     = bus.dm_req && !(bus.if_req && (starveCnt == LIMIT));
    assign ifWins     = !dmWins && bus.if_req && !bus.flush_if;
    assign ifFlushHit = (owner == OWNER_IF) && bus.flush_if;

    // A flush arriving in the DONE cycle still kills the fetch pulse.
    assign ifValid    = ifValidQ && !bus.flush_if;

    // Transaction FSM with registered memory command, read data and valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the read-data registers are reset along with the control
            // state because every output, data included, must read 0 in reset.
            state     <= IDLE;
            owner     <= OWNER_IF;
            discard   <= 1'b0;
            starveCnt <= '0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memBe     <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            ifRdata   <= '0;
            dmRdata   <= '0;
            ifValidQ  <= 1'b0;
            dmValidQ  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the default-low pulses
            // below are overridden by later assignments in the same block.
            ifValidQ <= 1'b0;
            dmValidQ <= 1'b0;

            case (state)
                IDLE: begin
                    if (dmWins) begin
                        owner    <= OWNER_DM;
                        discard  <= 1'b0;
                        memReq   <= 1'b1;
                        memWe    <= bus.dm_we;
                        memBe    <= bus.dm_be;
                        memAddr  <= bus.dm_addr;
                        memWdata <= bus.dm_wdata;
                        state    <= REQ;
                        if (bus.if_req && (starveCnt != LIMIT)) begin
                            starveCnt <= starveCnt + 4'd1;
                        end
                    end else if (ifWins) begin
                        owner     <= OWNER_IF;
                        discard   <= 1'b0;
                        memReq    <= 1'b1;
                        memWe     <= 1'b0;
                        memBe     <= '1;
                        memAddr   <= bus.if_addr;
                        memWdata  <= '0;
                        starveCnt <= '0;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (ifFlushHit) begin
                        discard <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        memReq <= 1'b0;
                        state  <= RESP;
                    end
                end

                RESP: begin
                    if (ifFlushHit) begin
                        discard <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        if (owner == OWNER_DM) begin
                            dmRdata  <= bus.mem_rdata;
                            dmValidQ <= 1'b1;
                            state    <= DONE;
                        end else if (discard || bus.flush_if) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            ifRdata  <= bus.mem_rdata;
                            ifValidQ <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_be    = memBe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

    assign bus.if_rdata  = ifRdata;
    assign bus.if_valid  = ifValid;
    assign bus.stall_if  = bus.if_req && !ifValid;

    assign bus.dm_rdata  = dmRdata;
    assign bus.dm_valid  = dmValidQ;
    assign bus.stall_dm  = bus.dm_req && !dmValidQ;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge. Memory responses are driven
// by hand, so every expected value below is written out directly.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   testCnt = 0;
    int   failCnt = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Move to the drive point of the next cycle.
    task automatic toEdge();
        @(posedge clk);
        #1;
    endtask

    // Move to the sample point of the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] dmTurn;

        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.flush_if   = 1'b0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_be      = '0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // ---------------- reset state
        mid();
        check("rst mem_req",  bus.mem_req,  0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst mem_be",   bus.mem_be,   0);
        check("rst if_valid", bus.if_valid, 0);
        check("rst dm_valid", bus.dm_valid, 0);
        check("rst if_rdata", bus.if_rdata, 0);
        check("rst dm_rdata", bus.dm_rdata, 0);
        check("rst stall_if", bus.stall_if, 0);
        check("rst stall_dm", bus.stall_dm, 0);

        // ---------------- single fetch
        toEdge(); rst_n = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h100;
        mid();
        check("t1 stall_if idle", bus.stall_if, 1);
        check("t1 mem_req idle",  bus.mem_req,  0);
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t1 mem_req req",   bus.mem_req,  1);
        check("t1 mem_addr",      bus.mem_addr, 32'h100);
        check("t1 mem_we",        bus.mem_we,   0);
        check("t1 mem_be",        bus.mem_be,   32'hF);
        toEdge(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00500093;
        mid();
        check("t1 mem_req resp",  bus.mem_req,  0);
        check("t1 if_valid resp", bus.if_valid, 0);
        check("t1 stall_if resp", bus.stall_if, 1);
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t1 if_valid done", bus.if_valid, 1);
        check("t1 if_rdata",      bus.if_rdata, 32'h00500093);
        check("t1 stall_if done", bus.stall_if, 0);
        toEdge(); bus.if_req = 1'b0;
        mid();
        check("t1 if_valid after", bus.if_valid, 0);
        check("t1 mem_req after",  bus.mem_req,  0);
        check("t1 if_rdata hold",  bus.if_rdata, 32'h00500093);

        // ---------------- store with grant backpressure
        toEdge();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'hF;
        bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEADBEEF;
        mid();
        check("t2 stall_dm idle", bus.stall_dm, 1);
        for (int i = 0; i < 3; i++) begin
            toEdge(); bus.mem_gnt = 1'b0;
            mid();
            check("t2 mem_req held",   bus.mem_req,   1);
            check("t2 mem_addr held",  bus.mem_addr,  32'h2000);
            check("t2 mem_wdata held", bus.mem_wdata, 32'hDEADBEEF);
            check("t2 mem_we held",    bus.mem_we,    1);
            check("t2 mem_be held",    bus.mem_be,    32'hF);
        end
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t2 mem_req at gnt", bus.mem_req, 1);
        toEdge(); bus.mem_gnt = 1'b0;
        mid();
        check("t2 mem_req resp",  bus.mem_req,  0);
        check("t2 stall_dm resp", bus.stall_dm, 1);
        toEdge(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
        mid();
        check("t2 dm_valid rvalid", bus.dm_valid, 0);
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t2 dm_valid done", bus.dm_valid, 1);
        check("t2 stall_dm done", bus.stall_dm, 0);
        toEdge(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        mid();
        check("t2 dm_valid after", bus.dm_valid, 0);

        // ---------------- contention, STARVE_LIMIT=4: DM x4, IF, DM x4, IF
        dmTurn = 10'b0111101111;
        toEdge();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            toEdge(); bus.mem_gnt = 1'b1;
            mid();
            check("t3 grant addr", bus.mem_addr, dmTurn[i] ? 32'h3000 : 32'h200);
            toEdge(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0000000 + 32'(i);
            toEdge(); bus.mem_rvalid = 1'b0;
            mid();
            if (dmTurn[i]) begin
                check("t3 dm_valid", bus.dm_valid, 1);
                check("t3 dm_rdata", bus.dm_rdata, 32'hA0000000 + 32'(i));
                check("t3 if_valid quiet", bus.if_valid, 0);
            end else begin
                check("t3 if_valid", bus.if_valid, 1);
                check("t3 if_rdata", bus.if_rdata, 32'hA0000000 + 32'(i));
                check("t3 dm_valid quiet", bus.dm_valid, 0);
            end
            toEdge();
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        mid();
        check("t3 idle after", bus.mem_req, 0);

        // ---------------- fetch flushed in RESP
        toEdge(); bus.if_req = 1'b1; bus.if_addr = 32'h400;
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t4 mem_addr", bus.mem_addr, 32'h400);
        toEdge(); bus.mem_gnt = 1'b0; bus.flush_if = 1'b1;
        mid();
        check("t4 if_valid flush", bus.if_valid, 0);
        toEdge(); bus.flush_if = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        bus.if_addr = 32'h500;
        mid();
        check("t4 if_valid rvalid", bus.if_valid, 0);
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t4 no pulse",       bus.if_valid, 0);
        check("t4 if_rdata kept",  bus.if_rdata, 32'hA0000009);
        check("t4 stall_if",       bus.stall_if, 1);
        check("t4 mem_req idle",   bus.mem_req,  0);
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t4 recapture req",  bus.mem_req,  1);
        check("t4 recapture addr", bus.mem_addr, 32'h500);
        toEdge(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A00113;
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t4 refetch valid", bus.if_valid, 1);
        check("t4 refetch rdata", bus.if_rdata, 32'h00A00113);
        toEdge(); bus.if_req = 1'b0;

        // ---------------- async reset while in RESP
        toEdge(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3004;
        toEdge(); bus.mem_gnt = 1'b1;
        toEdge(); bus.mem_gnt = 1'b0;
        #2; rst_n = 1'b0; bus.dm_req = 1'b0;
        #1;
        check("t5 mem_req",  bus.mem_req,  0);
        check("t5 mem_addr", bus.mem_addr, 0);
        check("t5 mem_be",   bus.mem_be,   0);
        check("t5 dm_rdata", bus.dm_rdata, 0);
        check("t5 if_rdata", bus.if_rdata, 0);
        check("t5 stall_dm", bus.stall_dm, 0);
        toEdge(); rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        mid();
        check("t5 stray rvalid dm_valid", bus.dm_valid, 0);
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t5 later dm_valid", bus.dm_valid, 0);
        check("t5 later if_valid", bus.if_valid, 0);
        check("t5 later dm_rdata", bus.dm_rdata, 0);
        check("t5 later mem_req",  bus.mem_req,  0);

        // ---------------- fetch then load back to back
        toEdge(); bus.if_req = 1'b1; bus.if_addr = 32'h600;
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t6 fetch addr", bus.mem_addr, 32'h600);
        toEdge(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00C00193;
        toEdge(); bus.mem_rvalid = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h2040;
        mid();
        check("t6 if_valid",  bus.if_valid, 1);
        check("t6 if_rdata",  bus.if_rdata, 32'h00C00193);
        check("t6 stall_dm",  bus.stall_dm, 1);
        toEdge(); bus.if_req = 1'b0;
        mid();
        check("t6 no reissue in done", bus.mem_req,  0);
        check("t6 if_valid single",    bus.if_valid, 0);
        toEdge(); bus.mem_gnt = 1'b1;
        mid();
        check("t6 load req",  bus.mem_req,  1);
        check("t6 load addr", bus.mem_addr, 32'h2040);
        check("t6 load we",   bus.mem_we,   0);
        toEdge(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        toEdge(); bus.mem_rvalid = 1'b0;
        mid();
        check("t6 dm_valid",     bus.dm_valid, 1);
        check("t6 dm_rdata",     bus.dm_rdata, 32'hCAFEF00D);
        check("t6 if_rdata kept", bus.if_rdata, 32'h00C00193);
        toEdge(); bus.dm_req = 1'b0;
        mid();
        check("t6 dm_valid after", bus.dm_valid, 0);
        check("t6 dm_rdata hold",  bus.dm_rdata, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
